// File: rtl/sync_fifo_pkg.sv
// sync_fifo_pkg: read-mode enum and width helpers shared by sync_fifo_v3 and its RAM
package sync_fifo_pkg;
  typedef enum logic {FIFO_STD, FIFO_FWFT} fifo_mode_e;
  function automatic int cnt_w(input int depth);
    return $clog2(depth + 1);
  endfunction
  function automatic int addr_w(input int depth);
    return $clog2(depth) > 1 ? $clog2(depth) : 1;
  endfunction
endpackage

// File: rtl/sync_fifo_ram.sv
// sync_fifo_ram: DEPTH x T storage with sync write and registered (REG_RD=1) or combinational read
module sync_fifo_ram #(
  parameter int DEPTH = 4,
  parameter type T = logic,
  parameter int AW = 2,
  parameter bit REG_RD = 1'b1
) (
  input logic clk,
  input logic rst,
  input logic we,
  input logic [AW-1:0] waddr,
  input T wdata,
  input logic re,
  input logic [AW-1:0] raddr,
  output T rdata
);
  T mem [DEPTH];
  T rd_q;
  always_ff @(posedge clk)
    if (we) mem[waddr] <= wdata;
  always_ff @(posedge clk)
    if (rst) rd_q <= '0;
    else if (re) rd_q <= mem[raddr];
  assign rdata = REG_RD ? rd_q : mem[raddr];
endmodule

// File: rtl/sync_fifo_v3.sv
// sync_fifo_v3: any-depth sync FIFO (clk, rst, wen/data_in, ren/data_out/rvalid, full/empty/almost flags, count); STD or FWFT read; SYNC_FIFO_V3_ERR_EN adds err_clr and sticky overflow/underflow
module sync_fifo_v3 import sync_fifo_pkg::*; #(
  parameter int DEPTH = 4,
  parameter type T = logic,
  parameter int FWFT = 0,
  parameter int AF_TH = DEPTH - 1,
  parameter int AE_TH = 1
) (
  input logic clk,
  input logic rst,
  input logic wen,
  input T data_in,
  input logic ren,
  output T data_out,
  output logic rvalid,
  output logic full,
  output logic empty,
  output logic almost_full,
  output logic almost_empty,
  output logic [cnt_w(DEPTH)-1:0] count
`ifdef SYNC_FIFO_V3_ERR_EN
  ,
  input logic err_clr,
  output logic overflow,
  output logic underflow
`endif
);
  localparam int AW = addr_w(DEPTH);
  localparam int CW = cnt_w(DEPTH);
  localparam fifo_mode_e MODE = FWFT != 0 ? FIFO_FWFT : FIFO_STD;
  typedef struct packed {
    logic wrap;
    logic [AW-1:0] addr;
  } ptr_t;
  ptr_t wptr, rptr;
  logic wa, ra, rv_q;
  function automatic ptr_t inc(input ptr_t p);
    return p.addr == AW'(DEPTH - 1) ? {~p.wrap, AW'(0)} : {p.wrap, p.addr + AW'(1)};
  endfunction
  assign wa = wen & ~full;
  assign ra = ren & ~empty;
  assign full = count == CW'(DEPTH);
  assign empty = count == '0;
  assign almost_full = count >= CW'(AF_TH);
  assign almost_empty = count <= CW'(AE_TH);
  assign rvalid = MODE == FIFO_FWFT ? ~empty : rv_q;
  always_ff @(posedge clk)
    if (rst) begin
      wptr <= '0;
      rptr <= '0;
      count <= '0;
      rv_q <= 1'b0;
    end else begin
      wptr <= wa ? inc(wptr) : wptr;
      rptr <= ra ? inc(rptr) : rptr;
      count <= count + CW'(wa) - CW'(ra);
      rv_q <= ra;
    end
  sync_fifo_ram #(
    .DEPTH(DEPTH),
    .T(T),
    .AW(AW),
    .REG_RD(MODE == FIFO_STD)
  ) u_ram (
    .clk(clk),
    .rst(rst),
    .we(wa),
    .waddr(wptr.addr),
    .wdata(data_in),
    .re(ra),
    .raddr(rptr.addr),
    .rdata(data_out)
  );
`ifdef SYNC_FIFO_V3_ERR_EN
  always_ff @(posedge clk)
    if (rst) begin
      overflow <= 1'b0;
      underflow <= 1'b0;
    end else begin
      overflow <= (wen & full) | (overflow & ~err_clr);
      underflow <= (ren & empty) | (underflow & ~err_clr);
    end
`endif
endmodule

// File: doc/sync_fifo_v3.md
Name: sync_fifo_v3

Overview:
Parametrised synchronous FIFO that succeeds the two-pointer/wrap-bit FIFO used across the datapath.
- Supports arbitrary (non-power-of-two) depth.
- Selectable read mode: registered read, or first-word-fall-through (FWFT).
- Provides a registered occupancy count and programmable almost-full/almost-empty flags.
- Protects against overflow and underflow.
- Drops in wherever single-clock buffering between pipeline stages is needed.

Parameters:
- DEPTH, 4, number of entries; any integer >= 2.
- T, logic, payload type (parameter type).
- FWFT, 0, 0 = registered read mode (STD); 1 = first-word-fall-through.
- AF_TH, DEPTH-1, almost_full asserts when count >= AF_TH; legal range 1..DEPTH.
- AE_TH, 1, almost_empty asserts when count <= AE_TH; legal range 0..DEPTH-1.

Ports:
- clk  in  1  clock; all state updates on posedge.
- rst  in  1  reset; synchronous, active-high.
- wen  in  1  write request.
- data_in  in  T  write data.
- ren  in  1  read request (STD) or pop (FWFT).
- data_out  out  T  read data.
- rvalid  out  1  STD: data_out updated this cycle. FWFT: equals !empty.
- full  out  1  count == DEPTH.
- empty  out  1  count == 0.
- almost_full  out  1  count >= AF_TH.
- almost_empty  out  1  count <= AE_TH.
- count  out  $clog2(DEPTH+1)  current occupancy.

Behaviour:
- Reset (rst high at posedge): waddr, raddr, wrap bits, count, rvalid <= 0; data_out <= '0 (STD). Memory contents are not reset.
- After reset: empty=1, full=0, almost_empty=1, almost_full=(AF_TH==0 ? 1 : 0). rst dominates wen/ren in the same cycle.
- Write accept: wa = wen & !full. Read accept: ra = ren & !empty. Both use the registered full/empty.
- Requests that are not accepted are silently dropped; state is unchanged.
- Pointers are ADDR_W = max(1, $clog2(DEPTH)) bits wide plus a wrap bit. On accept, a pointer increments; at DEPTH-1 it returns to 0 and its wrap bit toggles.
- count: +1 on wa&!ra, -1 on ra&!wa, unchanged when both or neither occur.
- Simultaneous wa&ra: both pointers advance and count holds.
- At full, wen&ren in the same cycle: read accepted, write rejected.
- At empty, wen&ren in the same cycle: write accepted, read rejected.
- All flags are decoded from registered count only. There is no combinational path from wen/ren to any flag.
- STD mode (FWFT=0):
  - data_out <= mem[raddr] on ra; latency 1 cycle.
  - rvalid = ra delayed by 1.
  - data_out holds its value otherwise.
- FWFT mode (FWFT=1):
  - data_out = mem[raddr] combinationally; latency 0.
  - Valid whenever !empty.
  - ra pops the head; the next entry appears in the same cycle the pop is registered.
  - A write into an empty FIFO becomes visible on data_out the cycle after it is accepted.
- Write and read of the same slot in one cycle (STD mode, count==1 with wa&ra): data_out gets the old entry. The new entry lands in the next slot.
- Reset mid-stream: all queued data is discarded; the first post-reset write is stored at address 0.

Optional Feature:
- Macro: SYNC_FIFO_V3_ERR_EN.
- Defined:
  - Adds ports overflow (out, 1), underflow (out, 1) and err_clr (in, 1).
  - overflow sets sticky on wen&full; underflow sets sticky on ren&empty.
  - Both flags clear on rst or err_clr. If a set and err_clr occur in the same cycle, set wins.
- Undefined: these ports and their logic do not exist; dropped requests go unreported.

Decomposition:
- Package sync_fifo_pkg:
  - fifo_mode_e enum {FIFO_STD, FIFO_FWFT}.
  - Function cnt_w(depth) returning $clog2(depth+1).
  - Function addr_w(depth) returning max(1, $clog2(depth)).
- Sub-module sync_fifo_ram: parametrised by DEPTH and T.
  - One synchronous write port.
  - One read port that is registered or combinational according to a parameter.
- Top level holds the pointers, count, flags and the optional error logic.

Test Plan:
1. DEPTH=5, STD: write 1..5 back-to-back.
   - full=1 with count=5 after the 5th write.
   - 6th wen is dropped; count stays 5.
   - Reads return 1..5, each with rvalid 1 cycle after ren; empty=1 after the 5th read.
2. DEPTH=5 wrap-around: 20 cycles of wen&ren from count=2 with an incrementing pattern.
   - count stays 2; output order is preserved across 4 wraps.
3. FWFT=1: write 0xA5 into an empty FIFO.
   - Next cycle data_out=0xA5 and rvalid=1.
   - ren pops; with a second entry 0x3C queued, data_out=0x3C in the following cycle.
4. AF_TH=3, AE_TH=1, DEPTH=4: fill one entry at a time.
   - almost_empty=1 for count 0..1.
   - almost_full rises exactly when count reaches 3.
   - Draining mirrors this.
5. Reset mid-stream: with count=3, pulse rst together with wen.
   - Next cycle count=0, empty=1, rvalid=0.
   - The subsequent write/read returns the new data only.
6. With SYNC_FIFO_V3_ERR_EN: ren on empty gives underflow=1, held across 10 idle cycles.
   - err_clr clears it.
   - wen on full gives overflow=1, and count does not change.
